// File: rtl/serdes_align_pkg.sv
// Shared types and default constants for the SERDES word aligner.
package serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } align_state_t;

  localparam logic [7:0] C_ALIGN_PATTERN = 8'h01;
  localparam int         C_SLIP_MAX      = 8;
  localparam int         C_SERDES8_CYCLE = 1;

endpackage

// File: rtl/serdes_word_gather.sv
// Packs aligned bytes MSB-first into 32-bit words with a one-clock valid strobe.
module serdes_word_gather (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data8,
  output logic [31:0] data32,
  output logic        data32_valid
);

  // Only the three previous bytes are needed; the current byte completes the word.
  logic [23:0] shift;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift        <= '0;
      byte_cnt     <= '0;
      data32       <= '0;
      data32_valid <= 1'b0;
    end else begin
      data32_valid <= 1'b0;
      if (clr) begin
        shift    <= '0;
        byte_cnt <= '0;
      end else if (en) begin
        shift    <= {shift[15:0], data8};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          data32       <= {shift, data8};
          data32_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serdes_word_align.sv
// Bitslip-driven byte aligner and 8->32 packer for the 1:8 DDR deserializer.
// Optional SERDES_WORD_ALIGN_STATS_EN adds slip_total_o / relock_cnt_o counters.
module serdes_word_align
  import serdes_align_pkg::*;
#(
  parameter logic [7:0] ALIGN_PATTERN = C_ALIGN_PATTERN,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SLIP_SETTLE   = 16,
  parameter int         SLIP_MAX      = C_SLIP_MAX,
  parameter int         SERDES8_CYCLE = C_SERDES8_CYCLE
) (
  input  logic        clk_rx_i,
  input  logic        rst,
  input  logic        serdes_lock_i,
  input  logic [7:0]  serdes_data8_i,
  output logic        serdes_bitslip_o,
  output logic        aligned_o,
  output logic [3:0]  slip_cnt_o,
  output logic        align_err_o,
  output logic [31:0] data32_o,
`ifdef SERDES_WORD_ALIGN_STATS_EN
  output logic [15:0] slip_total_o,
  output logic [7:0]  relock_cnt_o,
`endif
  output logic        data32_valid_o
);

  localparam logic [7:0] CYCLE_LAST  = 8'(SERDES8_CYCLE);
  localparam logic [3:0] MATCH_LAST  = 4'(MATCH_COUNT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SLIP_SETTLE - 1);
  localparam logic [3:0] SLIP_LAST   = 4'(SLIP_MAX - 1);

  align_state_t state;
  logic [7:0]   cnt8;
  logic [3:0]   match_cnt;
  logic [7:0]   settle_cnt;
  logic         strobe;
  logic         lock_loss;

  assign strobe    = (cnt8 == CYCLE_LAST);
  assign lock_loss = (state != ST_IDLE) && !serdes_lock_i;

  always_ff @(posedge clk_rx_i or posedge rst) begin
    if (rst) cnt8 <= '0;
    else     cnt8 <= strobe ? 8'd0 : cnt8 + 8'd1;
  end

  // Lock loss overrides every other event in the same cycle.
  always_ff @(posedge clk_rx_i or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      match_cnt        <= '0;
      settle_cnt       <= '0;
      slip_cnt_o       <= '0;
      serdes_bitslip_o <= 1'b0;
      aligned_o        <= 1'b0;
      align_err_o      <= 1'b0;
    end else begin
      serdes_bitslip_o <= 1'b0;
      if (lock_loss) begin
        state     <= ST_IDLE;
        aligned_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            slip_cnt_o <= '0;
            match_cnt  <= '0;
            if (serdes_lock_i) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (strobe) begin
              if (serdes_data8_i == ALIGN_PATTERN) begin
                if (match_cnt == MATCH_LAST) begin
                  state     <= ST_LOCKED;
                  aligned_o <= 1'b1;
                  match_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else begin
                match_cnt        <= '0;
                state            <= ST_SLIP;
                serdes_bitslip_o <= 1'b1;
              end
            end
          end
          ST_SLIP: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            if (slip_cnt_o == SLIP_LAST) begin
              slip_cnt_o  <= '0;
              align_err_o <= 1'b1;
            end else begin
              slip_cnt_o <= slip_cnt_o + 4'd1;
            end
          end
          ST_SETTLE: begin
            if (strobe) begin
              if (settle_cnt == SETTLE_LAST) begin
                state     <= ST_CHECK;
                match_cnt <= '0;
              end else begin
                settle_cnt <= settle_cnt + 8'd1;
              end
            end
          end
          ST_LOCKED: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  serdes_word_gather u_gather (
    .clk          (clk_rx_i),
    .rst          (rst),
    .en           (strobe && (state == ST_LOCKED)),
    .clr          (lock_loss),
    .data8        (serdes_data8_i),
    .data32       (data32_o),
    .data32_valid (data32_valid_o)
  );

`ifdef SERDES_WORD_ALIGN_STATS_EN
  always_ff @(posedge clk_rx_i or posedge rst) begin
    if (rst) begin
      slip_total_o <= '0;
      relock_cnt_o <= '0;
    end else begin
      if (serdes_bitslip_o && (slip_total_o != 16'hFFFF))
        slip_total_o <= slip_total_o + 16'd1;
      if (lock_loss && (state == ST_LOCKED) && (relock_cnt_o != 8'hFF))
        relock_cnt_o <= relock_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_word_align.sv
// Scoreboard bench for serdes_word_align with a rotating-byte deserializer model.
module tb_serdes_word_align;
  import serdes_align_pkg::*;

  logic        clk_rx_i = 1'b0;
  logic        rst = 1'b1;
  logic        serdes_lock_i = 1'b0;
  logic [7:0]  serdes_data8_i = 8'h00;
  logic        serdes_bitslip_o;
  logic        aligned_o;
  logic [3:0]  slip_cnt_o;
  logic        align_err_o;
  logic [31:0] data32_o;
  logic        data32_valid_o;
`ifdef SERDES_WORD_ALIGN_STATS_EN
  logic [15:0] slip_total_o;
  logic [7:0]  relock_cnt_o;
`endif

  int checks = 0;
  int passes = 0;
  int m_cnt;
  int step_no = 0;
  int pulse_cnt = 0;
  int last_pulse = 0;
  int clks;
  logic prev_bs = 1'b0;
  logic rot_mode = 1'b0;
  logic [7:0] rot_byte = 8'h00;
  logic [31:0] exp_q[$];

  serdes_word_align dut (
    .clk_rx_i         (clk_rx_i),
    .rst              (rst),
    .serdes_lock_i    (serdes_lock_i),
    .serdes_data8_i   (serdes_data8_i),
    .serdes_bitslip_o (serdes_bitslip_o),
    .aligned_o        (aligned_o),
    .slip_cnt_o       (slip_cnt_o),
    .align_err_o      (align_err_o),
    .data32_o         (data32_o),
`ifdef SERDES_WORD_ALIGN_STATS_EN
    .slip_total_o     (slip_total_o),
    .relock_cnt_o     (relock_cnt_o),
`endif
    .data32_valid_o   (data32_valid_o)
  );

  always #5 clk_rx_i = ~clk_rx_i;

  // Reference sample-slot counter: the next posedge is a strobe when m_cnt == cycle.
  always @(posedge clk_rx_i or posedge rst) begin
    if (rst) m_cnt <= 0;
    else     m_cnt <= (m_cnt == C_SERDES8_CYCLE) ? 0 : m_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every presented word is matched against the scoreboard queue.
  initial forever begin
    @(negedge clk_rx_i);
    if (data32_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %h, required no word", data32_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("word", data32_o, e);
        $display("word out %h expected %h", data32_o, e);
      end
    end
  end

  // One clock of the deserializer model: watch bitslip, rotate the byte on each pulse.
  task automatic step();
    int gap;
    @(negedge clk_rx_i);
    step_no++;
    if (serdes_bitslip_o) begin
      check("pulse_width", {31'b0, prev_bs}, 32'd0);
      if (pulse_cnt > 0) begin
        gap = step_no - last_pulse;
        checks++;
        if (gap >= 32) passes++;
        else $display("FAIL pulse_gap: got %0d clks, required >= 32", gap);
      end
      pulse_cnt++;
      last_pulse = step_no;
      if (rot_mode) begin
        rot_byte = {rot_byte[0], rot_byte[7:1]};
        serdes_data8_i = rot_byte;
      end
    end
    prev_bs = serdes_bitslip_o;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    while (m_cnt != C_SERDES8_CYCLE) step();
    serdes_data8_i = b;
  endtask

  task automatic wait_aligned(input int budget, output int n);
    n = 0;
    while (!aligned_o && n < budget) begin
      step();
      n++;
    end
    check("aligned_reached", {31'b0, aligned_o}, 32'd1);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("pulse_count_reached", pulse_cnt, target);
  endtask

  initial begin
    repeat (3) @(negedge clk_rx_i);
    check("rst_flags", {24'b0, aligned_o, serdes_bitslip_o, align_err_o, data32_valid_o, slip_cnt_o}, 32'd0);
    check("rst_data32", data32_o, 32'd0);

    // Already-aligned stream, then two constant words.
    rst = 1'b0;
    serdes_lock_i = 1'b1;
    serdes_data8_i = 8'h01;
    pulse_cnt = 0;
    wait_aligned(100, clks);
    check("t1_align_clks", clks, 32'd8);
    check("t1_pulses", pulse_cnt, 32'd0);
    exp_q.push_back(32'h01010101);
    exp_q.push_back(32'h01010101);
    repeat (8) send_byte(8'h01);

    // Byte ordering.
    exp_q.push_back(32'hA1B2C3D4);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    step();
    check("t4_valid", {31'b0, data32_valid_o}, 32'd1);
    check("t4_data", data32_o, 32'hA1B2C3D4);

    // Lock loss after two payload bytes.
    send_byte(8'h11);
    check("t4_valid_width", {31'b0, data32_valid_o}, 32'd0);
    send_byte(8'h22);
    step();
    serdes_lock_i = 1'b0;
    step();
    check("t5_aligned_drop", {31'b0, aligned_o}, 32'd0);
    check("t5_data_hold", data32_o, 32'hA1B2C3D4);
    check("t5_no_valid", {31'b0, data32_valid_o}, 32'd0);
    repeat (5) step();

    // Misaligned by 3: three slips to reach the pattern.
    rot_mode = 1'b1;
    rot_byte = 8'h08;
    serdes_data8_i = 8'h08;
    pulse_cnt = 0;
    serdes_lock_i = 1'b1;
    wait_aligned(600, clks);
    check("t2_pulses", pulse_cnt, 32'd3);
    check("t2_slip_cnt", {28'b0, slip_cnt_o}, 32'd3);
    check("t2_align_err", {31'b0, align_err_o}, 32'd0);
    serdes_lock_i = 1'b0;
    repeat (3) step();

    // Relock misaligned by 2: slip count restarts from zero.
    rot_byte = 8'h04;
    serdes_data8_i = 8'h04;
    pulse_cnt = 0;
    serdes_lock_i = 1'b1;
    wait_aligned(600, clks);
    check("t5_relock_slip_cnt", {28'b0, slip_cnt_o}, 32'd2);
    serdes_lock_i = 1'b0;
    repeat (3) step();

    // Never-matching stream: full rotation sets the sticky error.
    rot_byte = 8'h55;
    serdes_data8_i = 8'h55;
    pulse_cnt = 0;
    serdes_lock_i = 1'b1;
    wait_pulses(8, 1000);
    step();
    step();
    check("t3_err_set", {31'b0, align_err_o}, 32'd1);
    check("t3_slip_wrap", {28'b0, slip_cnt_o}, 32'd0);
    check("t3_not_aligned", {31'b0, aligned_o}, 32'd0);
    wait_pulses(9, 200);
    step();
    step();
    check("t3_err_sticky", {31'b0, align_err_o}, 32'd1);
    check("t3_slip_after_wrap", {28'b0, slip_cnt_o}, 32'd1);

    // Asynchronous reset while settling.
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("t6_async_flags", {24'b0, aligned_o, serdes_bitslip_o, align_err_o, data32_valid_o, slip_cnt_o}, 32'd0);
    check("t6_async_data32", data32_o, 32'd0);
    step();
    rot_mode = 1'b0;
    serdes_data8_i = 8'h01;
    pulse_cnt = 0;
    rst = 1'b0;
    wait_aligned(100, clks);
    check("t6_align_clks", clks, 32'd8);
    check("t6_no_pulses", pulse_cnt, 32'd0);
    serdes_lock_i = 1'b0;
    repeat (4) step();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
